// File: rtl/demux_pkg.sv
// Shared types and constants for the demux_stream_router block.
package demux_pkg;

  localparam int CNT_W = 16;

  typedef enum logic {CH_EMPTY, CH_FULL} ch_state_t;

endpackage

// File: rtl/demux_chan_buf.sv
// One-entry output buffer for a single router channel: fill, drain, clear-on-drain.
module demux_chan_buf
  import demux_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fill,
  input  logic [DW-1:0] in_data,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output ch_state_t     state
);

  logic drain;

  assign drain = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CH_EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        CH_EMPTY: begin
          if (fill) begin
            state     <= CH_FULL;
            out_valid <= 1'b1;
            out_data  <= in_data;
          end
        end
        CH_FULL: begin
          // Drain and fill in the same cycle keeps the slot full with no bubble.
          if (drain && fill) begin
            out_data <= in_data;
          end else if (drain) begin
            state     <= CH_EMPTY;
            out_valid <= 1'b0;
            out_data  <= '0;
          end
        end
        default: begin
          state     <= CH_EMPTY;
          out_valid <= 1'b0;
          out_data  <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/demux_stream_router.sv
// Registered 1-to-CH stream demultiplexer with explicit or round-robin targeting.
// Optional per-channel fill counters are enabled by defining DEMUX_COUNT_EN.
module demux_stream_router
  import demux_pkg::*;
#(
  parameter int CH = 4,
  parameter int DW = 8,
  localparam int SW = $clog2(CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [SW-1:0]    s,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic [CH-1:0]    out_valid,
  input  logic [CH-1:0]    out_ready,
  output logic [CH*DW-1:0] out_data,
  output logic [SW-1:0]    cur_sel,
  output logic             err_bad_sel
`ifdef DEMUX_COUNT_EN
  ,
  output logic [CH*CNT_W-1:0] cnt_out
`endif
);

  // Handshakes: a word moves when valid && ready are both high at a clk edge;
  // ready may depend combinationally on the consumer's ready, valid never on ready.

  logic [SW-1:0] rr_ptr;
  logic [SW-1:0] tgt;
  logic          bad_sel;
  logic          tgt_full;
  logic          tgt_oready;
  logic          accept;
  logic [CH-1:0] fill;
  ch_state_t     ch_state [CH];

  assign tgt     = mode ? rr_ptr : s;
  assign cur_sel = tgt;
  assign bad_sel = (int'(tgt) >= CH);

  // Loop-based lookup keeps an out-of-range target from indexing past the array.
  always_comb begin
    tgt_full   = 1'b0;
    tgt_oready = 1'b0;
    for (int k = 0; k < CH; k++) begin
      if (tgt == SW'(k)) begin
        tgt_full   = (ch_state[k] == CH_FULL);
        tgt_oready = out_ready[k];
      end
    end
  end

  assign in_ready = en && (bad_sel || !tgt_full || tgt_oready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    fill = '0;
    for (int k = 0; k < CH; k++) begin
      fill[k] = accept && !bad_sel && (tgt == SW'(k));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      err_bad_sel <= 1'b0;
    end else begin
      err_bad_sel <= accept && bad_sel;
      if (accept && mode) begin
        rr_ptr <= (rr_ptr == SW'(CH - 1)) ? '0 : rr_ptr + 1'b1;
      end
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_chan
    demux_chan_buf #(.DW(DW)) u_buf (
      .clk       (clk),
      .rst       (rst),
      .fill      (fill[k]),
      .in_data   (in_data),
      .out_ready (out_ready[k]),
      .out_valid (out_valid[k]),
      .out_data  (out_data[k*DW +: DW]),
      .state     (ch_state[k])
    );
  end

`ifdef DEMUX_COUNT_EN
  for (genvar k = 0; k < CH; k++) begin : g_cnt
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= '0;
      end else if (fill[k] && (cnt != {CNT_W{1'b1}})) begin
        cnt <= cnt + 1'b1;
      end
    end
    assign cnt_out[k*CNT_W +: CNT_W] = cnt;
  end
`endif

endmodule
